// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg
// Shared AHB-Lite definitions for master and slave: transfer type encoding,
// transfer size codes, response codes, the slave FSM state type and a helper
// that turns a transfer size/offset into a 4-bit byte-lane enable.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Byte lanes touched by a legal transfer; misaligned or oversize
    // transfers never reach the write path, so only legal cases matter.
    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] off);
        case (size)
            HSIZE_BYTE: return 4'b0001 << off;
            HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if
// AHB-Lite bus bundle between one master and one slave.
//   master modport: drives HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
//                   HMASTLOCK, HREADY, HWDATA; receives HRDATA, HREADYOUT, HRESP
//   slave modport : the mirror image
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem
// DEPTH x 32-bit word memory organised as four byte lanes.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset, clears every word
//   we_i    : write strobe
//   be_i    : byte-lane enables for the write
//   addr_i  : word index shared by write and read
//   wdata_i : write data
//   rdata_o : combinational read of the addressed word
module ahb_sram_mem #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int w = 0; w < DEPTH; w++) begin
                        lane_q[w] <= '0;
                    end
                end else if (we_i && be_i[gi]) begin
                    lane_q[addr_i] <= wdata_i[8*gi +: 8];
                end
            end

            assign rdata_o[8*gi +: 8] = lane_q[addr_i];
        end
    endgenerate

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
// AHB-Lite slave fronting a local word-addressed SRAM with programmable wait
// states and a two-cycle ERROR response for illegal transfers.
//   HCLK    : clock
//   HRESETn : synchronous active-low reset
//   bus     : AHB-Lite slave modport (address/control/write data in,
//             HRDATA/HREADYOUT/HRESP out)
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_sram_slave_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    slv_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       size_q, size_d;
    logic             write_q, write_d;

    logic        accept;
    logic        addr_err;
    logic [32:0] rel_addr;
    logic [31:0] mem_rdata;
    logic        mem_we;

    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];

    // 33-bit subtraction: bit 32 set means the address lies below BASE_ADDR.
    assign rel_addr = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};

    assign addr_err = (bus.HSIZE > HSIZE_WORD)
                   || (bus.HSIZE == HSIZE_HALF && bus.HADDR[0])
                   || (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00)
                   || rel_addr[32]
                   || (rel_addr[31:0] >= SPAN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all present HREADYOUT high, so a new
                // address phase can be taken from any of them.
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = rel_addr[IDX_W+1:2];
                    off_d   = bus.HADDR[1:0];
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Write lands on the edge that ends the DATA cycle; the memory's own
    // reset takes priority, so a write caught by reset is dropped.
    assign mem_we = (state_q == ST_DATA) && write_q;

    ahb_sram_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .we_i    (mem_we),
        .be_i    (lane_enable(size_q, off_q)),
        .addr_i  (idx_q),
        .wdata_i (bus.HWDATA),
        .rdata_o (mem_rdata)
    );

    assign bus.HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign bus.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? mem_rdata : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0], rel_addr};

endmodule
